// File: rtl/name_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : name_issue_queue
// Summary  : Buffers up to DEPTH NDN names and issues them over valid/ready
//            into the FIB lookup pipeline, with an optional replay loop.
// Revision : 1.0  initial release
// ============================================================================
module name_issue_queue #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_SIZE        = 4,
  parameter int DEPTH           = 8,
  parameter int POINTER_SIZE    = 3,
  parameter int COUNT_SIZE      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] wr_name,
  input  logic [LEN_SIZE-1:0]                  wr_len,
  output logic                                 wr_full,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 mode_replay,
  output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
  output logic [LEN_SIZE-1:0]                  name_len_out,
  output logic                                 name_valid,
  input  logic                                 name_ready,
  output logic [COUNT_SIZE-1:0]                issued_count,
  output logic                                 empty,
  output logic                                 busy,
  output logic                                 wr_err
);

  localparam int                      c_NAME_W    = MAX_NAME_LENGTH * WORD_SIZE;
  localparam logic [POINTER_SIZE:0]   c_DEPTH     = (POINTER_SIZE+1)'(DEPTH);
  localparam logic [POINTER_SIZE:0]   c_OCC_ONE   = (POINTER_SIZE+1)'(1);
  localparam logic [POINTER_SIZE-1:0] c_PTR_ONE   = POINTER_SIZE'(1);
  localparam logic [LEN_SIZE-1:0]     c_MAX_LEN   = LEN_SIZE'(MAX_NAME_LENGTH);
  localparam logic [COUNT_SIZE-1:0]   c_COUNT_ONE = COUNT_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0]   c_COUNT_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [c_NAME_W-1:0]     r_mem     [DEPTH];
  logic [LEN_SIZE-1:0]     r_mem_len [DEPTH];
  logic [POINTER_SIZE-1:0] r_head;
  logic [POINTER_SIZE-1:0] r_tail;
  logic [POINTER_SIZE-1:0] r_offset;
  logic [POINTER_SIZE:0]   r_occ;
  logic                    r_replay;
  logic                    r_stop_seen;
  logic                    r_valid;
  logic                    r_err;
  logic [c_NAME_W-1:0]     r_name_out;
  logic [LEN_SIZE-1:0]     r_len_out;
  logic [COUNT_SIZE-1:0]   r_count;

  logic [c_NAME_W-1:0]     w_wr_masked;
  logic                    w_run;
  logic                    w_full;
  logic                    w_len_ok;
  logic                    w_wr_ok;
  logic                    w_xfer;
  logic                    w_slot_free;
  logic                    w_stop_now;
  logic                    w_load;
  logic                    w_pop;
  logic                    w_start_ok;
  logic                    w_offset_wrap;
  logic [POINTER_SIZE-1:0] w_src_idx;

  // Unused words are zeroed on the way in so the output path needs no masking.
  for (genvar gi = 0; gi < MAX_NAME_LENGTH; gi++) begin : g_mask
    localparam logic [LEN_SIZE-1:0] c_IDX = LEN_SIZE'(gi);
    assign w_wr_masked[gi*WORD_SIZE +: WORD_SIZE] =
      (wr_len > c_IDX) ? wr_name[gi*WORD_SIZE +: WORD_SIZE] : '0;
  end

  assign w_run         = (r_state == S_RUN);
  assign w_full        = (r_occ == c_DEPTH);
  assign w_len_ok      = (wr_len != '0) && (wr_len <= c_MAX_LEN);
  assign w_wr_ok       = wr_en && !w_full && w_len_ok && !(w_run && r_replay);
  assign w_xfer        = r_valid && name_ready;
  assign w_slot_free   = !r_valid || w_xfer;
  assign w_stop_now    = stop || r_stop_seen;
  assign w_load        = w_run && w_slot_free && !w_stop_now && (r_occ != '0);
  assign w_pop         = w_load && !r_replay;
  assign w_start_ok    = !w_run && start && !stop && (r_occ != '0);
  assign w_src_idx     = r_replay ? (r_head + r_offset) : r_head;
  assign w_offset_wrap = ({1'b0, r_offset} == (r_occ - c_OCC_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A pending offer always completes before the run ends; a non-replay run
  // also ends once drained, unless a write is landing this very cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_slot_free &&
            (w_stop_now || (!r_replay && (r_occ == '0) && !w_wr_ok))) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_tail]     <= w_wr_masked;
      r_mem_len[r_tail] <= wr_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_offset    <= '0;
      r_occ       <= '0;
      r_replay    <= 1'b0;
      r_stop_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_name_out  <= '0;
      r_len_out   <= '0;
      r_count     <= '0;
    end else begin
      if (wr_en && !w_wr_ok) begin
        r_err <= 1'b1;
      end
      if (w_wr_ok) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC_ONE;
        2'b01:   r_occ <= r_occ - c_OCC_ONE;
        default: r_occ <= r_occ;
      endcase

      if (w_start_ok) begin
        r_replay <= mode_replay;
        r_offset <= '0;
      end else if (w_load && r_replay) begin
        r_offset <= w_offset_wrap ? '0 : (r_offset + c_PTR_ONE);
      end

      r_stop_seen <= w_run && w_stop_now && (w_state_next == S_RUN);

      if (w_load) begin
        r_valid    <= 1'b1;
        r_name_out <= r_mem[w_src_idx];
        r_len_out  <= r_mem_len[w_src_idx];
      end else if (w_xfer) begin
        r_valid    <= 1'b0;
      end

      if (w_xfer && (r_count != c_COUNT_MAX)) begin
        r_count <= r_count + c_COUNT_ONE;
      end
    end
  end

  assign wr_full      = w_full;
  assign empty        = (r_occ == '0);
  assign busy         = w_run;
  assign wr_err       = r_err;
  assign name_valid   = r_valid;
  assign name_out     = r_name_out;
  assign name_len_out = r_len_out;
  assign issued_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_name_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_name_issue_queue
// Summary  : Self-checking bench for name_issue_queue against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_name_issue_queue;

  localparam int WS = 32;
  localparam int ML = 8;
  localparam int LW = 4;
  localparam int DP = 8;
  localparam int NW = ML * WS;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [NW-1:0] wr_name;
  logic [LW-1:0] wr_len;
  logic          wr_full;
  logic          start;
  logic          stop;
  logic          mode_replay;
  logic [NW-1:0] name_out;
  logic [LW-1:0] name_len_out;
  logic          name_valid;
  logic          name_ready;
  logic [CW-1:0] issued_count;
  logic          empty;
  logic          busy;
  logic          wr_err;

  always #5 clk = ~clk;

  name_issue_queue #(
    .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_SIZE(LW),
    .DEPTH(DP), .POINTER_SIZE(3), .COUNT_SIZE(CW)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_name(wr_name),
    .wr_len(wr_len), .wr_full(wr_full), .start(start), .stop(stop),
    .mode_replay(mode_replay), .name_out(name_out),
    .name_len_out(name_len_out), .name_valid(name_valid),
    .name_ready(name_ready), .issued_count(issued_count), .empty(empty),
    .busy(busy), .wr_err(wr_err)
  );

  int checks = 0;
  int passes = 0;
  int cyc_cnt = 0;

  logic [NW-1:0] got_n[$];
  logic [LW-1:0] got_l[$];
  int            got_c[$];

  // Model: buffered names in write order, already masked to their length.
  logic [NW-1:0] mdl_n[$];
  logic [LW-1:0] mdl_l[$];
  logic          mdl_rep;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (!reset && name_valid && name_ready) begin
      got_n.push_back(name_out);
      got_l.push_back(name_len_out);
      got_c.push_back(cyc_cnt);
    end
  end

  function automatic logic [NW-1:0] mask_name(input logic [NW-1:0] n, input int len);
    logic [NW-1:0] r;
    r = n;
    for (int w = 0; w < ML; w++) begin
      if (w >= len) r[w*WS +: WS] = '0;
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_name();
    logic [NW-1:0] r;
    for (int w = 0; w < ML; w++) r[w*WS +: WS] = $urandom;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; wr_name = '0; wr_len = '0;
    start = 1'b0; stop = 1'b0; mode_replay = 1'b0; name_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    mdl_n.delete(); mdl_l.delete(); mdl_rep = 1'b0;
    got_n.delete(); got_l.delete(); got_c.delete();
  endtask

  task automatic wr(input logic [NW-1:0] n, input int len);
    logic [LW-1:0] l;
    l = len[LW-1:0];
    wr_en = 1'b1; wr_name = n; wr_len = l;
    if (len >= 1 && len <= ML && mdl_n.size() < DP && !mdl_rep) begin
      mdl_n.push_back(mask_name(n, len));
      mdl_l.push_back(l);
    end
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic rep);
    mode_replay = rep; start = 1'b1;
    if (rep && mdl_n.size() > 0) mdl_rep = 1'b1;
    cyc();
    start = 1'b0; mode_replay = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (name_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", name_valid); else passes++;
    checks++; if (name_out !== '0 || name_len_out !== '0) $display("FAIL reset_name: got len %0d name %h want 0", name_len_out, name_out); else passes++;
    checks++; if (issued_count !== '0 || wr_err !== 1'b0) $display("FAIL reset_cnt_err: got cnt %0d err %b want 0/0", issued_count, wr_err); else passes++;
    checks++; if (wr_full !== 1'b0 || empty !== 1'b1 || busy !== 1'b0) $display("FAIL reset_flags: got full %b empty %b busy %b want 0/1/0", wr_full, empty, busy); else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    wr(rand_name(), 3);
    wr(rand_name(), 8);
    wr(rand_name(), 1);
    name_ready = 1'b1;
    pulse_start(1'b0);
    wait_idle(30);
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle: got busy %b want 0", busy); else passes++;
    checks++; if (got_n.size() != 3) $display("FAIL basic_count: got %0d transfers want 3", got_n.size()); else passes++;
    for (int k = 0; k < 3 && k < got_n.size(); k++) begin
      checks++;
      if (got_n[k] !== mdl_n[k] || got_l[k] !== mdl_l[k])
        $display("FAIL basic_name[%0d]: got len %0d %h want len %0d %h", k, got_l[k], got_n[k], mdl_l[k], mdl_n[k]);
      else passes++;
    end
    if (got_c.size() == 3) begin
      checks++; if (got_c[2] - got_c[0] != 2) $display("FAIL basic_b2b: got span %0d want 2", got_c[2] - got_c[0]); else passes++;
      checks++; if (got_n[0][NW-1:3*WS] !== '0) $display("FAIL basic_zero: got %h want 0", got_n[0][NW-1:3*WS]); else passes++;
    end
    checks++; if (issued_count !== 16'd3 || empty !== 1'b1) $display("FAIL basic_end: got cnt %0d empty %b want 3/1", issued_count, empty); else passes++;
    name_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 3; i++) wr(rand_name(), int'($urandom_range(1, 8)));
    name_ready = 1'b1;
    pulse_start(1'b0);
    wait_idle(30);
    checks++; if (got_n.size() != 3 || busy !== 1'b0) $display("FAIL ovf_pre: got %0d transfers busy %b want 3/0", got_n.size(), busy); else passes++;
    mdl_n.delete(); mdl_l.delete(); got_n.delete(); got_l.delete(); got_c.delete();
    name_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(rand_name(), int'($urandom_range(1, 8)));
    checks++; if (wr_full !== 1'b1 || wr_err !== 1'b0) $display("FAIL ovf_full: got full %b err %b want 1/0", wr_full, wr_err); else passes++;
    wr(rand_name(), 4);
    checks++; if (wr_err !== 1'b1 || wr_full !== 1'b1) $display("FAIL ovf_drop: got err %b full %b want 1/1", wr_err, wr_full); else passes++;
    name_ready = 1'b1;
    pulse_start(1'b0);
    wait_idle(40);
    checks++; if (got_n.size() != 8) $display("FAIL ovf_count: got %0d transfers want 8", got_n.size()); else passes++;
    for (int k = 0; k < 8 && k < got_n.size(); k++) begin
      checks++;
      if (got_n[k] !== mdl_n[k] || got_l[k] !== mdl_l[k])
        $display("FAIL ovf_order[%0d]: got len %0d %h want len %0d %h", k, got_l[k], got_n[k], mdl_l[k], mdl_n[k]);
      else passes++;
    end
    checks++; if (issued_count !== 16'd11) $display("FAIL ovf_issued: got %0d want 11", issued_count); else passes++;
    name_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] held;
    do_reset();
    for (int i = 0; i < 3; i++) wr(rand_name(), int'($urandom_range(1, 8)));
    name_ready = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 10 && !name_valid; i++) cyc();
    checks++; if (name_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", name_valid); else passes++;
    held = name_out;
    checks++; if (held !== mdl_n[0]) $display("FAIL bp_first: got %h want %h", held, mdl_n[0]); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (name_out !== held || name_valid !== 1'b1 || issued_count !== '0)
        $display("FAIL bp_hold[%0d]: got valid %b cnt %0d name %h want 1/0 %h", i, name_valid, issued_count, name_out, held);
      else passes++;
      cyc();
    end
    name_ready = 1'b1;
    wait_idle(30);
    checks++; if (got_n.size() != 3 || issued_count !== 16'd3) $display("FAIL bp_drain: got %0d transfers cnt %0d want 3/3", got_n.size(), issued_count); else passes++;
    for (int k = 0; k < 3 && k < got_n.size(); k++) begin
      checks++;
      if (got_n[k] !== mdl_n[k]) $display("FAIL bp_order[%0d]: got %h want %h", k, got_n[k], mdl_n[k]); else passes++;
    end
    name_ready = 1'b0;
  endtask

  task automatic test_replay();
    do_reset();
    wr(rand_name(), int'($urandom_range(1, 8)));
    wr(rand_name(), int'($urandom_range(1, 8)));
    name_ready = 1'b1;
    pulse_start(1'b1);
    for (int i = 0; i < 60; i++) begin
      if (got_n.size() >= 6 && name_valid) begin
        stop = 1'b1; cyc(); stop = 1'b0;
        break;
      end
      if (i == 3) wr(rand_name(), 2); else cyc();
    end
    mdl_rep = 1'b0;
    checks++; if (busy !== 1'b0 || name_valid !== 1'b0) $display("FAIL rep_stop: got busy %b valid %b want 0/0", busy, name_valid); else passes++;
    checks++; if (got_n.size() != 7 || issued_count !== 16'd7) $display("FAIL rep_count: got %0d transfers cnt %0d want 7/7", got_n.size(), issued_count); else passes++;
    for (int k = 0; k < 7 && k < got_n.size(); k++) begin
      checks++;
      if (got_n[k] !== mdl_n[k % 2]) $display("FAIL rep_seq[%0d]: got %h want %h", k, got_n[k], mdl_n[k % 2]); else passes++;
    end
    checks++; if (wr_err !== 1'b1 || empty !== 1'b0) $display("FAIL rep_wr: got err %b empty %b want 1/0", wr_err, empty); else passes++;
    got_n.delete(); got_l.delete(); got_c.delete();
    pulse_start(1'b0);
    wait_idle(30);
    checks++; if (got_n.size() != 2 || empty !== 1'b1) $display("FAIL rep_occ: got %0d drained empty %b want 2/1", got_n.size(), empty); else passes++;
    for (int k = 0; k < 2 && k < got_n.size(); k++) begin
      checks++;
      if (got_n[k] !== mdl_n[k]) $display("FAIL rep_drain[%0d]: got %h want %h", k, got_n[k], mdl_n[k]); else passes++;
    end
    name_ready = 1'b0;
  endtask

  task automatic test_bad_len();
    do_reset();
    wr(rand_name(), 0);
    wr(rand_name(), 9);
    checks++; if (wr_err !== 1'b1 || empty !== 1'b1) $display("FAIL badlen_drop: got err %b empty %b want 1/1", wr_err, empty); else passes++;
    pulse_start(1'b0);
    checks++; if (busy !== 1'b0) $display("FAIL badlen_start: got busy %b want 0", busy); else passes++;
    cyc();
    checks++; if (busy !== 1'b0 || name_valid !== 1'b0) $display("FAIL badlen_idle: got busy %b valid %b want 0/0", busy, name_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] n;
    do_reset();
    wr(rand_name(), 6);
    wr(rand_name(), 2);
    name_ready = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 10 && !name_valid; i++) cyc();
    checks++; if (name_valid !== 1'b1) $display("FAIL rmid_valid: got %b want 1", name_valid); else passes++;
    reset = 1'b1;
    cyc();
    checks++; if (name_valid !== 1'b0 || name_out !== '0 || name_len_out !== '0) $display("FAIL rmid_out: got valid %b len %0d want 0/0", name_valid, name_len_out); else passes++;
    checks++; if (busy !== 1'b0 || empty !== 1'b1 || wr_full !== 1'b0 || wr_err !== 1'b0 || issued_count !== '0)
      $display("FAIL rmid_flags: got busy %b empty %b full %b err %b cnt %0d want 0/1/0/0/0", busy, empty, wr_full, wr_err, issued_count);
    else passes++;
    reset = 1'b0;
    mdl_n.delete(); mdl_l.delete(); mdl_rep = 1'b0;
    got_n.delete(); got_l.delete(); got_c.delete();
    n = rand_name();
    wr(n, 5);
    name_ready = 1'b1;
    pulse_start(1'b0);
    wait_idle(20);
    checks++; if (got_n.size() != 1 || issued_count !== 16'd1) $display("FAIL rmid_new: got %0d transfers cnt %0d want 1/1", got_n.size(), issued_count); else passes++;
    if (got_n.size() > 0) begin
      checks++; if (got_n[0] !== mask_name(n, 5) || got_l[0] !== 4'd5) $display("FAIL rmid_name: got len %0d %h want len 5 %h", got_l[0], got_n[0], mask_name(n, 5)); else passes++;
    end
    name_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_replay();
    test_bad_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
